// File: rtl/pc_pkg.sv
// Shared decode constants, condition codes and helpers for the LEGv8 PC sequencer.
package pc_pkg;

  typedef enum logic [2:0] {
    BK_SEQ, BK_B, BK_BL, BK_CBZ, BK_CBNZ, BK_BCOND, BK_BR, BK_RET
  } branch_kind_e;

  localparam logic [10:0] B_MASK      = 11'b111_1110_0000;
  localparam logic [10:0] CB_MASK     = 11'b111_1111_1000;
  localparam logic [10:0] FULL_MASK   = 11'b111_1111_1111;
  localparam logic [10:0] B_MATCH     = 11'b000_1010_0000;
  localparam logic [10:0] BL_MATCH    = 11'b100_1010_0000;
  localparam logic [10:0] CBZ_MATCH   = 11'b101_1010_0000;
  localparam logic [10:0] CBNZ_MATCH  = 11'b101_1010_1000;
  localparam logic [10:0] BCOND_MATCH = 11'b010_1010_0000;
  localparam logic [10:0] BR_MATCH    = 11'b110_1011_0000;
  localparam logic [10:0] RET_MATCH   = 11'b110_1011_0010;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_HS = 4'h2;
  localparam logic [3:0] COND_LO = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  // Priority decode: earlier matches shadow later ones.
  function automatic branch_kind_e decode_kind(input logic [10:0] op);
    branch_kind_e k;
    k = BK_SEQ;
    if ((op & B_MASK) == B_MATCH)               k = BK_B;
    else if ((op & B_MASK) == BL_MATCH)         k = BK_BL;
    else if ((op & CB_MASK) == CBZ_MATCH)       k = BK_CBZ;
    else if ((op & CB_MASK) == CBNZ_MATCH)      k = BK_CBNZ;
    else if ((op & CB_MASK) == BCOND_MATCH)     k = BK_BCOND;
    else if ((op & FULL_MASK) == BR_MATCH)      k = BK_BR;
    else if ((op & FULL_MASK) == RET_MATCH)     k = BK_RET;
    else                                        k = BK_SEQ;
    return k;
  endfunction

  // flags = {N, Z, C, V}
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v, p;
    n = flags[3];
    z = flags[2];
    c = flags[1];
    v = flags[0];
    case (cond)
      COND_EQ: p = z;
      COND_NE: p = ~z;
      COND_HS: p = c;
      COND_LO: p = ~c;
      COND_MI: p = n;
      COND_PL: p = ~n;
      COND_VS: p = v;
      COND_VC: p = ~v;
      COND_HI: p = c & ~z;
      COND_LS: p = ~(c & ~z);
      COND_GE: p = (n == v);
      COND_LT: p = (n != v);
      COND_GT: p = ~z & (n == v);
      COND_LE: p = ~(~z & (n == v));
      COND_AL: p = 1'b1;
      COND_NV: p = 1'b1;
      default: p = 1'b1;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               push_data,
  output logic [W-1:0]               top,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;

  // Entry storage, written at the push pointer.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and saturating occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else if (push) begin
      wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (count_r != CNT_FULL) begin
        count_r <= count_r + CNT_ONE;
      end
    end else if (pop && (count_r != '0)) begin
      wr_ptr_r <= wr_ptr_r - PTR_ONE;
      count_r  <= count_r - CNT_ONE;
    end
  end

  assign top   = mem_r[wr_ptr_r - PTR_ONE];
  assign empty = (count_r == '0);
  assign count = count_r;

endmodule

// File: rtl/pc_sequencer.sv
// LEGv8 program-counter sequencer. Optional return-address stack enabled by
// defining PC_RAS_EN; without it RET behaves exactly like BR.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int                PC_W      = 64,
  parameter int unsigned       INC       = 1,
  parameter logic [PC_W-1:0]   RESET_PC  = '0,
  parameter int                RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic [10:0]       opcode,
  input  logic [3:0]        cond,
  input  logic [3:0]        flags,
  input  logic [PC_W-1:0]   alu_result,
  input  logic [PC_W-1:0]   branch_offset,
  input  logic [PC_W-1:0]   reg_target,
  output logic [PC_W-1:0]   pc,
  output logic [PC_W-1:0]   pc_next,
  output logic [PC_W-1:0]   link_addr,
  output logic              taken,
  output logic              ras_empty
);

  localparam logic [PC_W-1:0] INC_W = PC_W'(INC);

  branch_kind_e    kind_s;
  logic [PC_W-1:0] pc_r;
  logic [PC_W-1:0] seq_s;
  logic [PC_W-1:0] rel_s;
  logic [PC_W-1:0] target_s;
  logic [PC_W-1:0] next_s;
  logic            taken_s;
  logic [PC_W-1:0] ret_target_s;

`ifdef PC_RAS_EN
  logic [PC_W-1:0]            ras_top_s;
  logic                       ras_empty_s;
  logic [$clog2(RAS_DEPTH):0] ras_count_s;
  logic                       push_s;
  logic                       pop_s;

  assign push_s       = (kind_s == BK_BL) && !stall;
  assign pop_s        = (kind_s == BK_RET) && (ras_count_s != '0) && !stall;
  assign ret_target_s = ras_empty_s ? reg_target : ras_top_s;
  assign ras_empty    = ras_empty_s;

  pc_ras #(.W(PC_W), .DEPTH(RAS_DEPTH)) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .pop       (pop_s),
    .push_data (seq_s),
    .top       (ras_top_s),
    .empty     (ras_empty_s),
    .count     (ras_count_s)
  );
`else
  assign ret_target_s = reg_target;
  assign ras_empty    = 1'b1;
`endif

  // Branch resolution and next-PC selection.
  always_comb begin
    kind_s   = decode_kind(opcode);
    seq_s    = pc_r + INC_W;
    rel_s    = pc_r + branch_offset;
    taken_s  = 1'b0;
    target_s = seq_s;
    case (kind_s)
      BK_B, BK_BL: begin
        taken_s  = 1'b1;
        target_s = rel_s;
      end
      BK_CBZ: begin
        taken_s  = (alu_result == '0);
        target_s = rel_s;
      end
      BK_CBNZ: begin
        taken_s  = (alu_result != '0);
        target_s = rel_s;
      end
      BK_BCOND: begin
        taken_s  = cond_pass(cond, flags);
        target_s = rel_s;
      end
      BK_BR: begin
        taken_s  = 1'b1;
        target_s = reg_target;
      end
      BK_RET: begin
        taken_s  = 1'b1;
        target_s = ret_target_s;
      end
      default: begin
        taken_s  = 1'b0;
        target_s = seq_s;
      end
    endcase
    next_s = taken_s ? target_s : seq_s;
  end

  // PC register; reset wins over stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r <= RESET_PC;
    end else if (!stall) begin
      pc_r <= next_s;
    end
  end

  assign pc        = pc_r;
  assign pc_next   = next_s;
  assign link_addr = seq_s;
  assign taken     = taken_s;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: table vectors, directed corner sequences
// and random stimulus against a queue-based reference model.
module tb_pc_sequencer;

  localparam int W = 64;
`ifdef PC_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif
  localparam int DEPTH = 4;

  localparam logic [10:0] OP_B     = 11'b00010100000;
  localparam logic [10:0] OP_BL    = 11'b10010100000;
  localparam logic [10:0] OP_CBZ   = 11'b10110100000;
  localparam logic [10:0] OP_CBNZ  = 11'b10110101000;
  localparam logic [10:0] OP_BCOND = 11'b01010100000;
  localparam logic [10:0] OP_BR    = 11'b11010110000;
  localparam logic [10:0] OP_RET   = 11'b11010110010;

  logic clk = 1'b0;
  logic rst, stall, taken, ras_empty;
  logic [10:0] opcode;
  logic [3:0] cond, flags;
  logic [W-1:0] alu_result, branch_offset, reg_target, pc, pc_next, link_addr;

  int total = 0;
  int bad = 0;
  longint unsigned m_pc;
  longint unsigned m_ras[$];
  logic dut_taken;
  logic [W-1:0] dut_link;

  pc_sequencer #(.PC_W(W), .INC(1), .RESET_PC('0), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .stall(stall), .opcode(opcode), .cond(cond),
    .flags(flags), .alu_result(alu_result), .branch_offset(branch_offset),
    .reg_target(reg_target), .pc(pc), .pc_next(pc_next),
    .link_addr(link_addr), .taken(taken), .ras_empty(ras_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ARM-style evaluation: base condition from code[3:1], odd codes invert (except 1111).
  function automatic bit m_cond(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cf, v, r;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c[3:1])
      3'd0: r = z;
      3'd1: r = cf;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = cf && !z;
      3'd5: r = (n == v);
      3'd6: r = !z && (n == v);
      default: r = 1'b1;
    endcase
    if (c[0] && c[3:1] != 3'd7) r = !r;
    return r;
  endfunction

  task automatic m_eval(output bit t, output longint unsigned nxt, output bit is_bl, output bit do_pop);
    longint unsigned rel;
    rel = m_pc + branch_offset;
    t = 1'b0; nxt = m_pc + 1; is_bl = 1'b0; do_pop = 1'b0;
    if (opcode ==? 11'b000101?????) begin t = 1'b1; nxt = rel; end
    else if (opcode ==? 11'b100101?????) begin t = 1'b1; nxt = rel; is_bl = 1'b1; end
    else if (opcode ==? 11'b10110100???) begin t = (alu_result == 0); if (t) nxt = rel; end
    else if (opcode ==? 11'b10110101???) begin t = (alu_result != 0); if (t) nxt = rel; end
    else if (opcode ==? 11'b01010100???) begin t = m_cond(cond, flags); if (t) nxt = rel; end
    else if (opcode == OP_BR) begin t = 1'b1; nxt = reg_target; end
    else if (opcode == OP_RET) begin
      t = 1'b1;
      if (RAS_ON && m_ras.size() > 0) begin nxt = m_ras[$]; do_pop = 1'b1; end
      else nxt = reg_target;
    end
  endtask

  // One clock: drive at negedge, check combinational outputs, clock, check pc.
  task automatic step(input logic [10:0] op, input logic [3:0] c, input logic [3:0] f,
                      input longint unsigned alu, input longint unsigned off,
                      input longint unsigned rt, input bit st, input bit r);
    bit t, is_bl, do_pop;
    longint unsigned nxt, link;
    opcode = op; cond = c; flags = f; alu_result = alu; branch_offset = off;
    reg_target = rt; stall = st; rst = r;
    #1;
    m_eval(t, nxt, is_bl, do_pop);
    link = m_pc + 1;
    dut_taken = taken;
    dut_link = link_addr;
    chk("taken", taken, t);
    chk("pc_next", pc_next, nxt);
    chk("link_addr", link_addr, link);
    chk("ras_empty", ras_empty, RAS_ON ? (m_ras.size() == 0) : 1'b1);
    @(posedge clk);
    if (r) begin
      m_pc = 0;
      m_ras.delete();
    end else if (!st) begin
      m_pc = nxt;
      if (do_pop) void'(m_ras.pop_back());
      if (is_bl && RAS_ON) begin
        m_ras.push_back(link);
        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      end
    end
    #1;
    chk("pc", pc, m_pc);
    @(negedge clk);
  endtask

  task automatic seq_n(input int n);
    for (int i = 0; i < n; i++) step(11'd0, 4'd0, 4'd0, 64'd1, 64'd0, 64'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(11'd0, 4'd0, 4'd0, 64'd1, 64'd0, 64'd0, 1'b0, 1'b1);
  endtask

  typedef struct {
    logic [10:0] op;
    logic [3:0]  c;
    logic [3:0]  f;
    logic [63:0] alu;
    logic        exp_taken;
  } vec_t;

  vec_t tbl[26];

  initial begin
    longint unsigned exp_ret[5];
    logic [10:0] rop;
    int k;

    tbl[0]  = '{OP_BCOND, 4'h0, 4'b0100, 64'd1, 1'b1};
    tbl[1]  = '{OP_BCOND, 4'h0, 4'b0000, 64'd1, 1'b0};
    tbl[2]  = '{OP_BCOND, 4'h1, 4'b0000, 64'd1, 1'b1};
    tbl[3]  = '{OP_BCOND, 4'h2, 4'b0010, 64'd1, 1'b1};
    tbl[4]  = '{OP_BCOND, 4'h3, 4'b0010, 64'd1, 1'b0};
    tbl[5]  = '{OP_BCOND, 4'h4, 4'b1000, 64'd1, 1'b1};
    tbl[6]  = '{OP_BCOND, 4'h5, 4'b1000, 64'd1, 1'b0};
    tbl[7]  = '{OP_BCOND, 4'h6, 4'b0001, 64'd1, 1'b1};
    tbl[8]  = '{OP_BCOND, 4'h7, 4'b0001, 64'd1, 1'b0};
    tbl[9]  = '{OP_BCOND, 4'h8, 4'b0010, 64'd1, 1'b1};
    tbl[10] = '{OP_BCOND, 4'h8, 4'b0110, 64'd1, 1'b0};
    tbl[11] = '{OP_BCOND, 4'h9, 4'b0110, 64'd1, 1'b1};
    tbl[12] = '{OP_BCOND, 4'hA, 4'b1001, 64'd1, 1'b1};
    tbl[13] = '{OP_BCOND, 4'hB, 4'b1000, 64'd1, 1'b1};
    tbl[14] = '{OP_BCOND, 4'hB, 4'b1001, 64'd1, 1'b0};
    tbl[15] = '{OP_BCOND, 4'hC, 4'b0000, 64'd1, 1'b1};
    tbl[16] = '{OP_BCOND, 4'hC, 4'b0100, 64'd1, 1'b0};
    tbl[17] = '{OP_BCOND, 4'hC, 4'b1000, 64'd1, 1'b0};
    tbl[18] = '{OP_BCOND, 4'hD, 4'b1000, 64'd1, 1'b1};
    tbl[19] = '{OP_BCOND, 4'hE, 4'b0000, 64'd1, 1'b1};
    tbl[20] = '{OP_BCOND, 4'hF, 4'b1111, 64'd1, 1'b1};
    tbl[21] = '{OP_CBZ,   4'h0, 4'b0000, 64'd0, 1'b1};
    tbl[22] = '{OP_CBZ,   4'h0, 4'b0000, 64'd3, 1'b0};
    tbl[23] = '{OP_CBNZ,  4'h0, 4'b0000, 64'd0, 1'b0};
    tbl[24] = '{OP_B,     4'h0, 4'b0000, 64'd0, 1'b1};
    tbl[25] = '{11'd0,    4'h0, 4'b0000, 64'd0, 1'b0};

    rst = 1'b1; stall = 1'b0; opcode = 11'd0; cond = 4'd0; flags = 4'd0;
    alu_result = '0; branch_offset = '0; reg_target = '0;
    @(negedge clk);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_pc", pc, 64'd0);
    chk("reset_ras_empty", ras_empty, 1'b1);
    m_pc = 0;
    @(negedge clk);
    rst = 1'b0;

    seq_n(5);
    chk("seq5_pc", pc, 64'd5);

    do_reset();
    seq_n(3);
    step(OP_CBNZ, 4'd0, 4'd0, 64'd5, 64'd8, 64'd0, 1'b0, 1'b0);
    chk("cbnz_taken_pc", pc, 64'd11);
    step(OP_CBNZ, 4'd0, 4'd0, 64'd0, 64'd8, 64'd0, 1'b0, 1'b0);
    chk("cbnz_not_taken_pc", pc, 64'd12);

    step(OP_BCOND, 4'hC, 4'b0000, 64'd0, 64'd8, 64'd0, 1'b0, 1'b0);
    chk("gt_taken", dut_taken, 1'b1);
    chk("gt_taken_pc", pc, 64'd20);
    step(OP_BCOND, 4'hC, 4'b0100, 64'd0, 64'd8, 64'd0, 1'b0, 1'b0);
    chk("gt_z_not_taken_pc", pc, 64'd21);
    step(OP_BCOND, 4'hE, 4'b0100, 64'd0, 64'd8, 64'd0, 1'b0, 1'b0);
    chk("al_taken_pc", pc, 64'd29);

    do_reset();
    step(OP_BR, 4'd0, 4'd0, 64'd0, 64'd0, 64'd20, 1'b0, 1'b0);
    chk("br_pc", pc, 64'd20);
    step(OP_BL, 4'd0, 4'd0, 64'd0, 64'd100, 64'd0, 1'b0, 1'b0);
    chk("bl_link", dut_link, 64'd21);
    chk("bl_pc", pc, 64'd120);
    step(OP_RET, 4'd0, 4'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0);
    chk("ret_pc", pc, RAS_ON ? 64'd21 : 64'd0);
    #1;
    chk("ret_ras_empty", ras_empty, 1'b1);

    do_reset();
    for (int i = 0; i < 5; i++) step(OP_BL, 4'd0, 4'd0, 64'd0, 64'd10, 64'd0, 1'b0, 1'b0);
    chk("bl5_pc", pc, 64'd50);
    exp_ret[0] = RAS_ON ? 64'd41 : 64'd999;
    exp_ret[1] = RAS_ON ? 64'd31 : 64'd999;
    exp_ret[2] = RAS_ON ? 64'd21 : 64'd999;
    exp_ret[3] = RAS_ON ? 64'd11 : 64'd999;
    exp_ret[4] = 64'd999;
    for (int i = 0; i < 5; i++) begin
      step(OP_RET, 4'd0, 4'd0, 64'd0, 64'd0, 64'd999, 1'b0, 1'b0);
      chk($sformatf("lifo_ret%0d", i), pc, exp_ret[i]);
    end

    do_reset();
    seq_n(2);
    for (int i = 0; i < 3; i++) begin
      step(OP_BL, 4'd0, 4'd0, 64'd0, 64'd7, 64'd0, 1'b1, 1'b0);
      chk("stall_pc", pc, 64'd2);
      #1;
      chk("stall_no_push", ras_empty, 1'b1);
    end
    step(OP_BL, 4'd0, 4'd0, 64'd0, 64'd7, 64'd0, 1'b0, 1'b0);
    chk("stall_release_pc", pc, 64'd9);
    step(OP_BL, 4'd0, 4'd0, 64'd0, 64'd7, 64'd0, 1'b1, 1'b1);
    chk("stall_rst_pc", pc, 64'd0);

    do_reset();
    for (int i = 0; i < 26; i++) begin
      step(tbl[i].op, tbl[i].c, tbl[i].f, tbl[i].alu, 64'd8, 64'd0, 1'b0, 1'b0);
      chk($sformatf("tbl%0d_taken", i), dut_taken, tbl[i].exp_taken);
    end

    for (int i = 0; i < 600; i++) begin
      k = $urandom_range(0, 8);
      case (k)
        0: rop = {6'b000101, 5'($urandom)};
        1: rop = {6'b100101, 5'($urandom)};
        2: rop = {8'b10110100, 3'($urandom)};
        3: rop = {8'b10110101, 3'($urandom)};
        4: rop = {8'b01010100, 3'($urandom)};
        5: rop = OP_BR;
        6: rop = OP_RET;
        7: rop = 11'd0;
        default: rop = 11'($urandom);
      endcase
      step(rop, 4'($urandom), 4'($urandom),
           ($urandom_range(0, 3) == 0) ? 64'd0 : {32'($urandom), 32'($urandom)},
           {32'($urandom), 32'($urandom)}, {32'($urandom), 32'($urandom)},
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 49) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the single-cycle LEGv8 datapath. Holds the PC and selects the next one for sequential, unconditional, compare-and-branch, flag-conditional and register-indirect control flow. Adds a stall hold, link-address generation for BL, and an optional return-address stack. Sits between the instruction decoder/ALU and instruction memory.

## Interface
- PC_W, 64: PC and address width.
- INC, 1: sequential increment; memory is word-addressed.
- RESET_PC, 0: PC value loaded on reset.
- RAS_DEPTH, 4: return-address stack entries, power of two, ≥2.
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- stall  in  1  hold PC and RAS this cycle.
- opcode  in  11  instruction[31:21].
- cond  in  4  B.cond field, instruction[3:0].
- flags  in  4  NZCV from flag register, [3]=N … [0]=V.
- alu_result  in  PC_W  compare operand for CBZ/CBNZ.
- branch_offset  in  PC_W  sign-extended, shifted offset.
- reg_target  in  PC_W  register value for BR/RET.
- pc  out  PC_W  current PC, registered.
- pc_next  out  PC_W  combinational next-PC.
- link_addr  out  PC_W  pc+INC, for X30 write on BL.
- taken  out  1  current instruction redirects.
- ras_empty  out  1  RAS has no valid entry; 1 when PC_RAS_EN undefined.

## Operation
- Decode on opcode bits; first match wins, else sequential:
  - B: [10:5]=000101.
  - BL: [10:5]=100101.
  - CBZ: [10:3]=10110100.
  - CBNZ: [10:3]=10110101.
  - B.cond: [10:3]=01010100.
  - BR: 11010110000.
  - RET: 11010110010.
- Relative target pc+branch_offset, mod 2^PC_W; sequential pc+INC, wraps.
- B, BL always taken, relative target. CBZ taken iff alu_result==0; CBNZ iff alu_result!=0.
- B.cond codes: 0 EQ Z, 1 NE !Z, 2 HS C, 3 LO !C, 4 MI N, 5 PL !N, 6 VS V, 7 VC !V, 8 HI C&!Z, 9 LS !(C&!Z), A GE N==V, B LT N!=V, C GT !Z&(N==V), D LE inverse of GT, E/F always.
- BR: taken, target reg_target. RET: taken, target per Configuration.
- pc_next = target if taken else pc+INC; pc <= pc_next unless stall.
- stall: pc, RAS unchanged; taken/pc_next still computed.
- Reset: pc=RESET_PC, RAS empty. Reset overrides stall.

## Timing
- pc registered, 1-cycle update; pc_next, taken, link_addr combinational from pc and inputs, 0 latency.
- RAS push/pop occurs on the same edge as the PC update; both are suppressed by stall or rst.

## Configuration
- PC_RAS_EN defined:
  - BL pushes link_addr. On full, the oldest entry is overwritten; circular pointer, count saturates at RAS_DEPTH.
  - RET with RAS non-empty targets the top entry and pops it; when empty, it targets reg_target.
  - ras_empty reflects count==0.
- PC_RAS_EN undefined: no storage; RET behaves as BR; ras_empty tied 1.

## Structure
- Package pc_pkg:
  - opcode match constants and masks.
  - cond-code localparams EQ…AL.
  - branch-kind enum {SEQ,B,BL,CBZ,CBNZ,BCOND,BR,RET}.
- Sub-module pc_ras: circular return-address stack with push, pop, top, empty, and count. Instantiated only under PC_RAS_EN.

## Test plan
- Reset with rst=1 for 2 cycles, RESET_PC=0 -> pc=0; 5 cycles opcode=0 -> pc=5.
- pc=3, CBNZ, alu_result=5, offset=8 -> pc=11. Then CBNZ, alu_result=0 -> pc=12.
- B.cond GT: flags N=0 Z=0 V=0 -> taken. Same with Z=1 -> pc+1. Cond=E -> always taken.
- pc=20, BL offset=100 -> link_addr=21, pc=120. Then RET, reg_target=0:
  - with PC_RAS_EN -> pc=21, ras_empty=1.
  - without PC_RAS_EN -> pc=0.
- 5 BLs, RAS_DEPTH=4 -> 4 RETs return the four newest links in LIFO order. A 5th RET falls back to reg_target.
- stall=1 for 3 cycles during B -> pc constant, no push. Releasing stall -> pc=target. Asserting rst while stalled -> pc=RESET_PC.
